sop_func_engine: RTL and testbench

- Programmable, registered multi-function Boolean evaluator: successor to the team's hard-wired 4-input sum-of-products function blocks.
- Each of N_FUNC channels holds a 2^N_IN-entry truth table, loaded bit-wise at runtime. All channels are evaluated in parallel on one input vector, and the result is registered.
- A sweep engine walks every input combination and reports the minterm count per channel, for self-check of loaded tables.

---
 rtl/sop_func_engine.sv | 114 +++++++++++
 tb/tb_sop_func_engine.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sop_func_engine.sv
// sop_func_engine: runtime-loadable multi-channel truth-table evaluator with minterm-count sweep
module sop_func_engine #(
  parameter int N_IN   = 4,
  parameter int N_FUNC = 2,
  parameter int SEL_W  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [SEL_W-1:0]           cfg_sel,
  input  logic [N_IN-1:0]            cfg_addr,
  input  logic                       cfg_bit,
  output logic                       cfg_drop,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_IN-1:0]            in_vec,
  output logic                       out_valid,
  output logic [N_FUNC-1:0]          out_f,
  input  logic                       sweep_start,
  output logic                       sweep_busy,
  output logic                       sweep_done,
  output logic [N_FUNC*(N_IN+1)-1:0] sweep_cnt
);
  localparam int DEPTH = 1 << N_IN;
  localparam int CW    = N_IN + 1;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t                     r_state, w_next;
  logic [DEPTH-1:0]           r_tbl [N_FUNC];
  logic [CW-1:0]              r_acc [N_FUNC];
  logic [N_IN:0]              r_addr;
  logic                       r_drop, r_out_valid;
  logic [N_FUNC-1:0]          r_out_f;
  logic [N_FUNC*CW-1:0]       r_cnt;
  logic                       w_idle, w_wr_ok, w_accept, w_last;

  assign w_idle   = r_state == IDLE;
  assign w_wr_ok  = cfg_we && w_idle && (int'(cfg_sel) < N_FUNC);
  assign w_accept = in_valid && w_idle;
  assign w_last   = r_addr == CW'(DEPTH - 1);

  assign cfg_drop  = r_drop;
  assign out_valid = r_out_valid;
  assign out_f     = r_out_f;
  assign sweep_cnt = r_cnt;

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  // next state and state-decoded status outputs
  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    sweep_busy = 1'b0;
    sweep_done = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        w_next   = sweep_start ? SWEEP : IDLE;
      end
      SWEEP: begin
        sweep_busy = 1'b1;
        w_next     = w_last ? DONE : SWEEP;
      end
      DONE: begin
        sweep_done = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // truth-table storage; writes land only in IDLE on an existing channel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < N_FUNC; k++) r_tbl[k] <= '0;
      r_drop <= 1'b0;
    end else begin
      for (int k = 0; k < N_FUNC; k++)
        if (w_wr_ok && cfg_sel == SEL_W'(k)) r_tbl[k][cfg_addr] <= cfg_bit;
      r_drop <= cfg_we && !w_wr_ok;
    end

  // evaluation pipeline; the table read sees pre-write contents on a shared edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_f     <= '0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept)
        for (int k = 0; k < N_FUNC; k++) r_out_f[k] <= r_tbl[k][in_vec];
    end

  // sweep datapath: clear accumulators at start, publish counts on the last address
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_addr <= '0;
      r_cnt  <= '0;
      for (int k = 0; k < N_FUNC; k++) r_acc[k] <= '0;
    end else if (w_idle && sweep_start) begin
      r_addr <= '0;
      for (int k = 0; k < N_FUNC; k++) r_acc[k] <= '0;
    end else if (r_state == SWEEP) begin
      r_addr <= r_addr + 1'b1;
      for (int k = 0; k < N_FUNC; k++) begin
        r_acc[k] <= r_acc[k] + CW'(r_tbl[k][r_addr[N_IN-1:0]]);
        if (w_last) r_cnt[k*CW +: CW] <= r_acc[k] + CW'(r_tbl[k][r_addr[N_IN-1:0]]);
      end
    end
endmodule

// File: tb/tb_sop_func_engine.sv
// tb_sop_func_engine: directed table-driven checks of the truth-table evaluator and sweep engine
module tb_sop_func_engine;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [0:0] cfg_sel = '0;
  logic [3:0] cfg_addr = '0;
  logic       cfg_bit = 1'b0;
  logic       cfg_drop;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_vec = '0;
  logic       out_valid;
  logic [1:0] out_f;
  logic       sweep_start = 1'b0;
  logic       sweep_busy;
  logic       sweep_done;
  logic [9:0] sweep_cnt;

  int n_run = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] vec;
    logic [1:0] f;
  } vec_t;
  vec_t tv [9];

  sop_func_engine #(.N_IN(4), .N_FUNC(2), .SEL_W(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_bit(cfg_bit), .cfg_drop(cfg_drop),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_f(out_f),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done), .sweep_cnt(sweep_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic sel, input logic [3:0] addr, input logic b);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_bit = b;
    tick;
    cfg_we = 1'b0;
    chk("wr_no_drop", cfg_drop, 0);
  endtask

  task automatic eval(input string nm, input logic [3:0] v, input logic [1:0] exp);
    in_valid = 1'b1; in_vec = v;
    tick;
    in_valid = 1'b0;
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_f"}, out_f, exp);
  endtask

  task automatic do_sweep(input string nm, input logic [9:0] exp_cnt);
    int b;
    sweep_start = 1'b1;
    tick;
    sweep_start = 1'b0;
    b = 0;
    while (sweep_busy === 1'b1 && b < 40) begin
      b++;
      tick;
    end
    chk({nm, "_busy_cycles"}, b, 16);
    chk({nm, "_done"}, sweep_done, 1);
    chk({nm, "_cnt"}, sweep_cnt, exp_cnt);
    chk({nm, "_ready_in_done"}, in_ready, 0);
    tick;
    chk({nm, "_done_pulse"}, sweep_done, 0);
    chk({nm, "_ready_after"}, in_ready, 1);
  endtask

  initial begin
    int b, bad;
    tv[0] = '{4'b0101, 2'b01};
    tv[1] = '{4'b0011, 2'b00};
    tv[2] = '{4'b1000, 2'b01};
    tv[3] = '{4'b1101, 2'b01};
    tv[4] = '{4'b1111, 2'b00};
    tv[5] = '{4'b0001, 2'b01};
    tv[6] = '{4'b0010, 2'b01};
    tv[7] = '{4'b0000, 2'b00};
    tv[8] = '{4'b1100, 2'b01};

    #12;
    chk("rst_out_f", out_f, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_drop", cfg_drop, 0);
    chk("rst_busy", sweep_busy, 0);
    chk("rst_done", sweep_done, 0);
    chk("rst_cnt", sweep_cnt, 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("rst_ready", in_ready, 1);

    eval("empty_eval", 4'b0101, 2'b00);
    tick;
    chk("idle_valid", out_valid, 0);
    do_sweep("sweep_empty", 10'd0);

    foreach (tv[i]) if (tv[i].f[0]) wr(1'b0, tv[i].vec, 1'b1);

    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_vec = tv[i].vec;
      tick;
      chk($sformatf("tbl_valid_%0d", i), out_valid, 1);
      chk($sformatf("tbl_f_%0d", i), out_f, tv[i].f);
    end
    in_valid = 1'b0;
    tick;
    chk("hold_valid", out_valid, 0);
    chk("hold_f", out_f, 2'b01);

    do_sweep("sweep_ch0", {5'd0, 5'd6});

    for (int a = 0; a < 16; a++) wr(1'b1, 4'(a), 1'b1);
    do_sweep("sweep_ch1", {5'd16, 5'd6});

    sweep_start = 1'b1;
    tick;
    sweep_start = 1'b0;
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'd3; cfg_bit = 1'b1;
    in_valid = 1'b1; in_vec = 4'b0101;
    tick;
    cfg_we = 1'b0;
    chk("busy_drop", cfg_drop, 1);
    chk("busy_ready", in_ready, 0);
    chk("busy_no_eval", out_valid, 0);
    tick;
    chk("busy_drop_pulse", cfg_drop, 0);
    b = 0; bad = 0;
    while (sweep_busy === 1'b1 && b < 40) begin
      b++;
      if (out_valid !== 1'b0) bad++;
      tick;
    end
    chk("busy_held_no_eval", bad, 0);
    chk("held_done", sweep_done, 1);
    chk("held_cnt", sweep_cnt, {5'd16, 5'd6});
    chk("held_done_no_eval", out_valid, 0);
    tick;
    chk("held_ready", in_ready, 1);
    chk("held_idle_no_eval", out_valid, 0);
    tick;
    in_valid = 1'b0;
    chk("held_accept_valid", out_valid, 1);
    chk("held_accept_f", out_f, 2'b11);

    do_sweep("resweep", {5'd16, 5'd6});
    eval("addr3_unchanged", 4'b0011, 2'b10);

    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'd5; cfg_bit = 1'b0;
    in_valid = 1'b1; in_vec = 4'b0101;
    tick;
    cfg_we = 1'b0; in_valid = 1'b0;
    chk("rbw_old_f", out_f, 2'b11);
    chk("rbw_drop", cfg_drop, 0);
    eval("rbw_new", 4'b0101, 2'b10);

    in_valid = 1'b1; in_vec = 4'b1111; sweep_start = 1'b1;
    tick;
    in_valid = 1'b0; sweep_start = 1'b0;
    chk("both_valid", out_valid, 1);
    chk("both_f", out_f, 2'b10);
    chk("both_busy", sweep_busy, 1);
    repeat (6) tick;
    chk("abort_still_busy", sweep_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", sweep_busy, 0);
    chk("abort_done", sweep_done, 0);
    chk("abort_cnt", sweep_cnt, 0);
    chk("abort_f", out_f, 0);
    chk("abort_valid", out_valid, 0);
    tick;
    tick;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (sweep_done !== 1'b0) bad++;
      tick;
    end
    chk("abort_no_done", bad, 0);
    eval("cleared_1111", 4'b1111, 2'b00);
    eval("cleared_0001", 4'b0001, 2'b00);
    eval("cleared_1100", 4'b1100, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
